// File: rtl/dds_pkg.sv
// Shared definitions for the DDS cores and the command parser:
// register addresses and waveform mode encodings.
package dds_pkg;

  localparam logic [1:0] ADDR_TUNE  = 2'd0;
  localparam logic [1:0] ADDR_PHASE = 2'd1;
  localparam logic [1:0] ADDR_CTRL  = 2'd2;

  typedef enum logic [1:0] {
    MODE_SAW    = 2'd0,
    MODE_SQUARE = 2'd1,
    MODE_TRI    = 2'd2,
    MODE_DC     = 2'd3
  } mode_e;

endpackage

// File: rtl/dds_channel.sv
// One DDS channel: active register set, phase accumulator, waveform
// shaping and the registered sample/wrap outputs.
module dds_channel
  import dds_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             clr_i,
  input  logic [ACC_W-1:0] m_i,
  input  logic [ACC_W-1:0] ph_i,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  output logic [OUT_W-1:0] sample_o,
  output logic             wrap_o
);

  localparam logic [OUT_W-1:0] MIDSCALE = OUT_W'(1) << (OUT_W - 1);

  logic [ACC_W-1:0] m_q, ph_q, acc_q, acc_d;
  logic             en_q, live_q, wrap_q, wrap_d, carry;
  mode_e            mode_q;
  logic [ACC_W-1:0] sum, p;
  logic [OUT_W-1:0] t, u, sample_q, sample_d;
  logic             unused_p;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    {carry, sum} = {1'b0, acc_q} + {1'b0, m_q};
    acc_d  = acc_q;
    wrap_d = 1'b0;
    if (clr_i) begin
      acc_d  = '0;
    end else if (en_q) begin
      acc_d  = sum;
      wrap_d = carry;
    end
  end

  assign p        = acc_q + ph_q;
  assign t        = p[ACC_W-1 -: OUT_W];
  assign u        = p[ACC_W-2 -: OUT_W];
  assign unused_p = ^{p, 1'b0};

  // The output stays at 0 from reset until the first commit, even for disabled channels.
  always_comb begin
    sample_d = '0;
    if (live_q) begin
      if (!en_q) begin
        sample_d = MIDSCALE;
      end else begin
        case (mode_q)
          MODE_SAW:    sample_d = t;
          MODE_SQUARE: sample_d = {OUT_W{p[ACC_W-1]}};
          MODE_TRI:    sample_d = p[ACC_W-1] ? ~u : u;
          default:     sample_d = MIDSCALE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q      <= '0;
      ph_q     <= '0;
      en_q     <= 1'b0;
      mode_q   <= MODE_SAW;
      live_q   <= 1'b0;
      acc_q    <= '0;
      wrap_q   <= 1'b0;
      sample_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
      if (load_i) begin
        m_q    <= m_i;
        ph_q   <= ph_i;
        en_q   <= en_i;
        mode_q <= mode_e'(mode_i);
        live_q <= 1'b1;
      end
      acc_q    <= acc_d;
      wrap_q   <= wrap_d;
      sample_q <= sample_d;
    end
  end

  assign sample_o = sample_q;
  assign wrap_o   = wrap_q;

endmodule

// File: rtl/dds_multi.sv
// Multi-channel DDS: shadow register file with write decode, and a single
// update strobe that commits every channel on the same edge.
module dds_multi
  import dds_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ACC_W  = 32,
  parameter int OUT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [2:0]              wr_ch,
  input  logic [1:0]              wr_addr,
  input  logic [ACC_W-1:0]        wr_data,
  input  logic                    update,
  input  logic                    phase_rst,
  output logic [NUM_CH*OUT_W-1:0] out,
  output logic [NUM_CH-1:0]       wrap
);

  logic clr;
  assign clr = update & phase_rst;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [ACC_W-1:0] m_s_q, m_s_d, ph_s_q, ph_s_d;
    logic             en_s_q, en_s_d;
    logic [1:0]       mode_s_q, mode_s_d;
    logic [OUT_W-1:0] sample;

    // Channel indices at or above NUM_CH have no generate block, so they never match.
    always_comb begin
      m_s_d    = m_s_q;
      ph_s_d   = ph_s_q;
      en_s_d   = en_s_q;
      mode_s_d = mode_s_q;
      if (wr_en && (wr_ch == 3'(k))) begin
        case (wr_addr)
          ADDR_TUNE:  m_s_d  = wr_data;
          ADDR_PHASE: ph_s_d = wr_data;
          ADDR_CTRL: begin
            en_s_d   = wr_data[2];
            mode_s_d = wr_data[1:0];
          end
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        m_s_q    <= '0;
        ph_s_q   <= '0;
        en_s_q   <= 1'b0;
        mode_s_q <= '0;
      end else begin
        m_s_q    <= m_s_d;
        ph_s_q   <= ph_s_d;
        en_s_q   <= en_s_d;
        mode_s_q <= mode_s_d;
      end
    end

    // Feeding the next-state shadow values gives write-through when a write meets update.
    dds_channel #(
      .ACC_W (ACC_W),
      .OUT_W (OUT_W)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .load_i   (update),
      .clr_i    (clr),
      .m_i      (m_s_d),
      .ph_i     (ph_s_d),
      .en_i     (en_s_d),
      .mode_i   (mode_s_d),
      .sample_o (sample),
      .wrap_o   (wrap[k])
    );

    assign out[k*OUT_W +: OUT_W] = sample;
  end

endmodule

// File: doc/dds_multi.md
# dds_multi

Parametrised multi-channel direct digital synthesis core, the successor to the single-channel `dds`. It holds NUM_CH independent phase accumulators, each with its own tuning word, phase offset and waveform mode, and produces one OUT_W-bit sample per channel per clock. Register writes from the command parser (`communication`) go into shadow registers. A single `update` strobe commits all channels in the same cycle, so channels can be retuned phase-coherently.

## Interface
- NUM_CH, default 2: number of channels (1..8).
- ACC_W, default 32: phase accumulator and tuning word width.
- OUT_W, default 8: sample width per channel (OUT_W ≤ ACC_W-1).
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  one-cycle write strobe into the shadow registers.
- wr_ch  in  3  target channel; writes with wr_ch ≥ NUM_CH are ignored.
- wr_addr  in  2  register select: 0 tuning word, 1 phase offset, 2 control {en=bit2, mode=bits1:0}; 3 ignored.
- wr_data  in  ACC_W  write data (control uses bits 2:0 only).
- update  in  1  commit all shadow registers to the active set.
- phase_rst  in  1  sampled with update: when 1, clears every accumulator at commit.
- out  out  NUM_CH*OUT_W  packed samples; channel k occupies bits [k*OUT_W +: OUT_W].
- wrap  out  NUM_CH  per-channel one-cycle pulse on accumulator overflow.

## Operation
- Per channel, there are shadow registers {m_s, ph_s, en_s, mode_s} and active registers {m, ph, en, mode}. All reset to 0.
- A write updates the selected shadow register on the next clock edge. Active registers are unaffected until update.
- On update, all active registers load from their shadows on the same edge. If wr_en and update coincide, the commit uses the new write value (write-through).
- Accumulator: if en, acc <= acc + m mod 2^ACC_W; otherwise acc holds. wrap[k] = 1 in the cycle after an addition carries out of bit ACC_W-1.
- If update && phase_rst: acc <= 0 for all channels on the commit edge, no wrap is generated, and accumulation resumes with the new m on the following edge.
- Sample phase p = acc + ph mod 2^ACC_W. Let T = p[ACC_W-1 -: OUT_W] and U = p[ACC_W-2 -: OUT_W].
- mode 0 sawtooth: T.
- mode 1 square: p[ACC_W-1] ? all-ones : 0.
- mode 2 triangle: p[ACC_W-1] ? ~U : U.
- mode 3 DC midscale: 2^(OUT_W-1).
- en = 0: out[k] holds midscale 2^(OUT_W-1), and wrap[k] = 0.
- m = 0 with en = 1: accumulator frozen, output is static at the current phase.

## Timing
- Output is registered: out in cycle t+1 reflects acc and the active registers in cycle t.
- Latency from the update edge to the first sample using the new settings is 1 cycle.
- Reset: acc = 0, all registers = 0, out = 0, wrap = 0, held while rst = 1.
- Reset asserted mid-operation clears everything asynchronously. The first accumulation occurs on the first clock edge after release only if a channel was enabled through writes plus update (impossible immediately after reset), so all channels stay idle until configured.
- No back-pressure. Writes are accepted every cycle; back-to-back writes to the same register keep the last one.

## Structure
- Sub-module `dds_channel`: one accumulator, active registers, waveform mux, output register and wrap flag. It is instantiated NUM_CH times via generate.
- `dds_multi` holds the shadow register file, the write decode and the update/phase_rst fan-out.
- Shared package `dds_pkg`: register address constants (ADDR_TUNE=0, ADDR_PHASE=1, ADDR_CTRL=2) and mode constants (MODE_SAW=0, MODE_SQUARE=1, MODE_TRI=2, MODE_DC=3), also used by `communication`.

## Test plan
- **Reset:** assert rst mid-run → out = 0 and wrap = 0 immediately. After release with no writes, out stays 0 until update, then reads 0x80 for every channel (en = 0).
- **Sawtooth:** ch0 m = 0x01000000, ctrl = 0b100, update → out[7:0] steps 0x00, 0x01, 0x02…. With ACC_W = 32, wrap[0] pulses every 256 cycles.
- **Shadowing:** write ch1 m = 0x40000000 without update → ch1 output unchanged. Issue update with phase_rst = 1 → both accumulators clear, ch1 square toggles every 2 cycles, and no wrap occurs on the commit cycle.
- **Phase offset:** ch0 and ch1 both sawtooth with m = 0x01000000, ch1 ph = 0x80000000, update with phase_rst → out[15:8] = out[7:0] ^ 0x80 every cycle.
- **Triangle:** m = 0x00800000 → output rises 0x00…0xFF, then falls 0xFF…0x00, with no glitch at the MSB crossing.
- **Edge cases:** wr_ch = NUM_CH and wr_addr = 3 writes leave all state unchanged. Simultaneous wr_en + update commits the new value in the same edge.
